// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the ShiftRows / InvShiftRows byte permutation.
// State byte k sits at bits [8k+7:8k]; row = k/4, column = k%4.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;

    function automatic int byte_off(input int row, input int col);
        return ((4 * row) + col) * BYTE_W;
    endfunction

    // Row r rotates left by r for encrypt, right by r for decrypt; row 0 is fixed.
    function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] state,
                                                      input logic               inv);
        logic [STATE_W-1:0] res;
        int                 src_col;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src_col = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                res[byte_off(r, c) +: BYTE_W] = state[byte_off(r, src_col) +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_rows_stage.sv
// One valid/ready register slice carrying {valid, data, tag}.
// Latency 1 cycle; ready = empty or downstream ready, so a full chain stalls combinationally.
module shift_rows_stage
    import aes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [STATE_W-1:0] up_data_i,
    input  logic [TAG_W-1:0]   up_tag_i,
    output logic               dn_valid_o,
    input  logic               dn_ready_i,
    output logic [STATE_W-1:0] dn_data_o,
    output logic [TAG_W-1:0]   dn_tag_o
);

    logic               valid_q, valid_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    assign up_ready_o = !valid_q || dn_ready_i;

    // Payload only moves with a real beat, keeping the output stable while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
                tag_d  = up_tag_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_tag_o   = tag_q;

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows/InvShiftRows (per-beat select) followed by a STAGES-deep valid/ready pipeline.
// Latency STAGES cycles; combinational ready chain, full throughput, synchronous flush.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [2:0]         occupancy
);

    // Index 0 is the transformed input; index i is the output of stage i.
    logic [STAGES:0]              stg_vld;
    logic [STAGES:0]              stg_rdy;
    logic [STAGES:0][STATE_W-1:0] stg_dat;
    logic [STAGES:0][TAG_W-1:0]   stg_tag;
    logic [2:0]                   occ_cnt;

    assign stg_vld[0]      = in_valid && !flush;
    assign stg_dat[0]      = shift_rows(in_data, in_inv);
    assign stg_tag[0]      = in_tag;
    assign stg_rdy[STAGES] = out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        shift_rows_stage #(
            .TAG_W (TAG_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid_i (stg_vld[g]),
            .up_ready_o (stg_rdy[g]),
            .up_data_i  (stg_dat[g]),
            .up_tag_i   (stg_tag[g]),
            .dn_valid_o (stg_vld[g+1]),
            .dn_ready_i (stg_rdy[g+1]),
            .dn_data_o  (stg_dat[g+1]),
            .dn_tag_o   (stg_tag[g+1])
        );
    end

    always_comb begin
        occ_cnt = '0;
        for (int i = 1; i <= STAGES; i++) begin
            occ_cnt = occ_cnt + {2'b00, stg_vld[i]};
        end
    end

    assign in_ready  = stg_rdy[0] && !flush;
    assign out_valid = stg_vld[STAGES];
    assign out_data  = stg_dat[STAGES];
    assign out_tag   = stg_tag[STAGES];
    assign occupancy = occ_cnt;

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, flow-controlled successor of the registered ShiftRows stage in the AES datapath. It applies either ShiftRows (encrypt) or InvShiftRows (decrypt), selected per beat, to a 128-bit state. Results pass through a configurable-depth valid/ready pipeline that carries a sideband tag and supports a synchronous flush. It sits between SubBytes and MixColumns in both the encrypt and decrypt round datapaths.

## Interface
Parameters:
- STAGES, 2, number of register stages (legal 1..4); sets latency.
- TAG_W, 4, width of the sideband tag carried with each beat (legal ≥1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- flush  in  1  synchronous flush; discards every in-flight beat.
- in_valid  in  1  input beat present.
- in_ready  out  1  pipeline can accept the input beat.
- in_data  in  128  state; byte k = in_data[8k+7:8k], row r = k/4, column c = k%4.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  in  TAG_W  opaque sideband, passed through unchanged.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  128  transformed state.
- out_tag  out  TAG_W  tag of the output beat.
- occupancy  out  3  number of valid beats held in the pipeline (0..STAGES).

## Operation
- Transform (combinational, before stage 1):
  - Forward: out byte 4r+c = in byte 4r+((c+r) mod 4).
  - Inverse: out byte 4r+c = in byte 4r+((c−r) mod 4).
  - Row 0 is unchanged in both modes.
- Pipeline: STAGES registers, each holding {valid, data, tag}.
  - Stage i ready = !valid_i || ready_(i+1); the last stage's ready is out_ready.
  - Stage i loads when its ready is high. It takes stage i−1 (or the transformed input for i=1) and sets valid from the upstream valid.
- Handshake:
  - in_ready = stage-1 ready && !flush.
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - out_valid = last-stage valid; out_data/out_tag come from the last-stage register.
  - Once out_valid is asserted, out_data and out_tag hold stable until consumed.
- Data and tag registers change only on load. Their values while the stage is not valid are don't-care but must not be X after reset.
- occupancy = count of set valid bits (registered counter or popcount; both must agree every cycle).
- Flush: on the edge where flush=1, all valid bits clear and occupancy becomes 0. No input is accepted in that cycle. An out_ready in that cycle completes no transfer that the bench must count.
- Reset: all valid bits 0, data and tag registers 0, occupancy 0. Reset mid-stream drops all in-flight beats immediately (asynchronous).

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES−1, i.e. visible in the cycle after acceptance for STAGES=1. This assumes no back-pressure.
- Throughput: 1 beat/cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational ready chain), with no bubble.
- Simultaneous accept and consume when full: both occur; occupancy is unchanged.
- Mode is per beat: alternating in_inv on consecutive beats must produce correctly alternating transforms with no stall.
- Outputs after reset release: out_valid=0, in_ready=1, out_data=0, out_tag=0, occupancy=0.

## Structure
- Shared package aes_pkg holds:
  - STATE_W=128 and BYTE_W=8 constants.
  - Byte-index helper function for (row, col) → bit offset.
  - The shift_rows(state, inv) function, reused by the key schedule tests.
- One sub-module, shift_rows_stage: a single valid/ready register slice (data+tag+valid), instantiated STAGES times by a generate loop.

## Test plan
- Forward: in_data=0x0f0e0d0c_0b0a0908_07060504_03020100, in_inv=0, STAGES=2, out_ready=1 → after 2 cycles out_data=0x0e0d0c0f_09080b0a_04070605_03020100.
- Inverse: same in_data, in_inv=1 → out_data=0x0c0f0e0d_09080b0a_06050407_03020100. Apply inverse to the forward result → original data.
- Back-pressure: out_ready=0, stream 5 tagged beats (tags 1..5) with STAGES=2.
  - Required: in_ready falls after 2 accepts; occupancy=2; out_data/out_tag stable.
  - Release out_ready → tags 1..5 emerge in order at 1/cycle with no loss or duplication.
- Mixed mode streaming: 8 back-to-back beats alternating in_inv=0/1 with random data → each output matches the reference function; throughput 1/cycle.
- Flush: occupancy=2, assert flush one cycle → next cycle out_valid=0, occupancy=0. The beat offered during flush is not accepted (in_ready=0).
- Reset mid-stream: assert rst asynchronously between edges with occupancy=2 → out_valid, occupancy, out_data drop to 0 immediately. After release, the first new beat appears with normal latency.
